dtcm_ahb_slave: RTL
===================

Name: dtcm_ahb_slave

Overview:
- AHB-lite slave fronting the data TCM; consumes the MAU's AHB master outputs and drives the core's dtcm_hready, dtcm_hresp and dtcm_hrdata.
- Register-array storage with byte-lane writes, a configurable wait-state counter, and a two-cycle ERROR response.
- Forwards write data to an overlapping back-to-back read so zero-wait pipelined load-after-store returns the new value.

Parameters:
- BASE_ADDR, 32'h2000_0000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two.
- WAIT_STATES, 0, extra data-phase cycles with hreadyout=0 per OKAY transfer; range 0..15.

Ports:
- hclk  in  1  clock.
- hrst  in  1  synchronous reset, active-high.
- hsel  in  1  slave select.
- haddr  in  32  address-phase byte address.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  in  1  1 = write.
- hsize  in  3  0 = byte, 1 = half, 2 = word; other values are illegal.
- hburst  in  3  ignored.
- hprot  in  7  ignored.
- hmastlock  in  1  ignored.
- hwdata  in  32  data-phase write data.
- hready  in  1  bus-level HREADY (transfer-accept qualifier).
- hreadyout  out  1  slave ready; feeds dtcm_hready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  32  registered read data.

Behaviour:
- Reset (hrst high at a rising edge):
  - state=IDLE; hreadyout=1, hresp=0, hrdata=0; wait counter cleared.
  - Any in-flight transfer is dropped with no memory write.
  - Memory array is not cleared.
- Address-phase accept when hsel & htrans[1] & hready at a rising edge. Latch addr, write, size and byte enables.
- Legality is checked at accept:
  - illegal if offset = haddr-BASE_ADDR >= DEPTH_WORDS*4 (unsigned, 32-bit wrap);
  - illegal if hsize > 2.
  - IDLE/BUSY or hsel=0 with hready=1 gives a zero-wait OKAY and no access.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: legal accept with WAIT_STATES=0 → IDLE (pipelined: the next cycle is a completing data phase). Legal accept with WAIT_STATES>0 → WAIT, count=WAIT_STATES. Illegal accept → ERR1.
  - WAIT: hreadyout=0; decrement; at count=1 → IDLE. Data phase completes in the following cycle.
  - ERR1: hreadyout=0, hresp=1 → ERR2.
  - ERR2: hreadyout=1, hresp=1; new accepts are allowed, same rules as IDLE.
- OKAY data phase lasts WAIT_STATES+1 cycles; hreadyout=1 only in the last one.
- Write commit:
  - Commits at the edge ending the completing data phase, using hwdata from that cycle.
  - Byte enables: byte → lane haddr[1:0]; half → lanes {haddr[1],0}+{0,1}; word → all four lanes.
- Read load:
  - hrdata is loaded from mem[word index] at the edge that enters the completing data phase.
  - That edge is the accept edge when WAIT_STATES=0, or the edge leaving WAIT otherwise. hrdata is held until the next load.
- Simultaneous events:
  - A write committing on the same edge as a read load to the same word: enabled lanes come from hwdata, the rest from mem.
  - ERROR transfers never write and never load hrdata.
- Misaligned legal-range accesses (without the optional feature): the low address bits are ignored for word; bit 0 is ignored for half.

Optional Feature:
- Macro: DTCM_MISALIGN_ERR_EN.
- Defined: word with haddr[1:0]≠0, or half with haddr[0]=1, is treated as illegal and gets the two-cycle ERROR with no write.
- Undefined: address is aligned down as above and the response is OKAY.

Decomposition:
- Package dtcm_pkg holds:
  - HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ;
  - HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD;
  - the state enum dtcm_state_t {IDLE, WAIT, ERR1, ERR2}.
- One sub-module, dtcm_byte_lane: combinational hsize and haddr[1:0] to 4-bit byte enable, plus the misalign flag.

Test Plan:
- WAIT_STATES=0: write word 0xDEADBEEF @0x2000_0010, then read @0x2000_0010 → hrdata=0xDEADBEEF with hreadyout=1 and hresp=0 in each data phase.
- Byte write 0xAA (hwdata=0xAA00_0000) @0x2000_0013 after the above, then read word → 0xAAADBEEF. Then halfword 0x1234 @0x2000_0010 → 0xAAAD1234.
- WAIT_STATES=0 pipelined: write 0x5555_5555 @0x2000_0020 immediately followed by a read @0x2000_0020 (read accept on the write's data-phase edge) → hrdata=0x5555_5555 via forwarding.
- Read @0x2000_1000 with DEPTH_WORDS=1024 → ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1); a prior write @0x2000_1000 leaves all words unchanged.
- WAIT_STATES=2: read → hreadyout low exactly 2 cycles, then high with correct data. hrst asserted during the first wait cycle → next cycle hreadyout=1, hresp=0, hrdata=0; memory contents intact.
- DTCM_MISALIGN_ERR_EN defined: word write @0x2000_0012 → two-cycle ERROR, memory unchanged. Undefined: same access writes word 0x2000_0010.

Source files
------------

// File: rtl/dtcm_pkg.sv
// Shared AHB-lite encodings, FSM state type and lane-merge helper for the DTCM slave.
package dtcm_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } dtcm_state_t;

  // Enabled lanes come from new_w, the rest from old_w.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dtcm_ahb_slave_if.sv
// AHB-lite bus bundle between the MAU master and the DTCM slave.
interface dtcm_ahb_slave_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [6:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
    input  hready, hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/dtcm_byte_lane.sv
// Decodes transfer size and low address bits into byte enables and a misalignment flag.
module dtcm_byte_lane
  import dtcm_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] be_c_o,
  output logic       misalign_c_o
);

  always_comb begin
    be_c_o       = 4'b0000;
    misalign_c_o = 1'b0;
    case (size_i)
      HSIZE_BYTE: be_c_o = 4'(4'b0001 << addr_lo_i);
      HSIZE_HALF: begin
        be_c_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misalign_c_o = addr_lo_i[0];
      end
      HSIZE_WORD: begin
        be_c_o       = 4'b1111;
        misalign_c_o = |addr_lo_i;
      end
      default: be_c_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/dtcm_ahb_slave.sv
// AHB-lite data-TCM slave: register-array storage, wait states, two-cycle ERROR, store-to-load forwarding.
// Optional: define DTCM_MISALIGN_ERR_EN to turn misaligned half/word accesses into ERROR responses.
module dtcm_ahb_slave
  import dtcm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic             hclk,
  input logic             hrst,
  dtcm_ahb_slave_if.slave bus
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  dtcm_state_t      state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             dp_valid_q, dp_valid_d;
  logic             dp_write_q, dp_write_d;
  logic [IDX_W-1:0] dp_idx_q, dp_idx_d;
  logic [3:0]       dp_be_q, dp_be_d;
  logic             hreadyout_q, hreadyout_d;
  logic             hresp_q, hresp_d;
  logic [31:0]      hrdata_q;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic [31:0]      offset_c;
  logic [IDX_W-1:0] idx_c;
  logic [3:0]       be_c;
  logic             misalign_c;
  logic             illegal_c;
  logic             accept_c;
  logic             commit_c;
  logic             load_c;
  logic [IDX_W-1:0] load_idx_c;
  logic [31:0]      load_data_c;
  logic             unused_c;

  dtcm_byte_lane u_byte_lane (
    .size_i       (bus.hsize),
    .addr_lo_i    (bus.haddr[1:0]),
    .be_c_o       (be_c),
    .misalign_c_o (misalign_c)
  );

  assign offset_c = bus.haddr - BASE_ADDR;
  assign idx_c    = offset_c[IDX_W+1:2];
  assign accept_c = bus.hsel & bus.htrans[1] & bus.hready &
                    ((state_q == IDLE) | (state_q == ERR2));

`ifdef DTCM_MISALIGN_ERR_EN
  assign illegal_c = (offset_c >= MEM_BYTES) | (bus.hsize > HSIZE_WORD) | misalign_c;
`else
  assign illegal_c = (offset_c >= MEM_BYTES) | (bus.hsize > HSIZE_WORD);
`endif

  assign unused_c = ^{bus.hburst, bus.hprot, bus.hmastlock, misalign_c};

  // A pending legal write completes in the IDLE cycle that follows its accept or wait states.
  assign commit_c = (state_q == IDLE) & dp_valid_q & dp_write_q;

  // Read data source, with the same-edge write merged in so back-to-back load-after-store sees new data.
  always_comb begin
    load_c     = 1'b0;
    load_idx_c = idx_c;
    if (WAIT_STATES == 0) begin
      load_c = accept_c & ~illegal_c & ~bus.hwrite;
    end else begin
      load_c     = (state_q == WAIT) & (cnt_q == 4'd1) & ~dp_write_q;
      load_idx_c = dp_idx_q;
    end
    load_data_c = mem_q[load_idx_c];
    if (commit_c && (dp_idx_q == load_idx_c)) begin
      load_data_c = merge_lanes(load_data_c, bus.hwdata, dp_be_q);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_idx_d   = dp_idx_q;
    dp_be_d    = dp_be_q;
    case (state_q)
      IDLE, ERR2: begin
        state_d    = IDLE;
        dp_valid_d = 1'b0;
        if (accept_c) begin
          dp_valid_d = ~illegal_c;
          dp_write_d = bus.hwrite;
          dp_idx_d   = idx_c;
          dp_be_d    = be_c;
          if (illegal_c) begin
            state_d = ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = IDLE;
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
    hreadyout_d = (state_d == IDLE) | (state_d == ERR2);
    hresp_d     = (state_d == ERR1) | (state_d == ERR2);
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_idx_q    <= '0;
      dp_be_q     <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_idx_q    <= dp_idx_d;
      dp_be_q     <= dp_be_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      if (load_c) hrdata_q <= load_data_c;
    end
  end

  // Storage is never reset; an in-flight write is dropped when reset lands on its commit edge.
  always_ff @(posedge hclk) begin
    if (!hrst && commit_c) begin
      mem_q[dp_idx_q] <= merge_lanes(mem_q[dp_idx_q], bus.hwdata, dp_be_q);
    end
  end

  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign bus.hrdata    = hrdata_q;

endmodule
